mem_arb_ram: RTL and testbench

- Parametrised successor to the TBX two-port Ibex "RAM" arbiter.
- Serves NUM_PORTS OBI-style request channels (port 0 = instr, port 1 = data, extra ports for DMA/debug) into one single-ported internal memory array.
- Arbitration is fixed-priority or round-robin. Read latency is configurable. Out-of-range accesses return an error response.
- Sits in the TBX BFM between the Ibex core and the backdoor-loaded memory.

---
 rtl/mem_arb_ram.sv | 198 +++++++++++++++++++
 tb/tb_mem_arb_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ram.sv
// mem_arb_ram: multi-port OBI-style arbiter in front of one single-ported word memory.
//
// Each requestor channel is arbitrated onto the single memory port, either by fixed priority
// (lowest index wins) or by round-robin. Every accepted request returns exactly one
// response READ_LATENCY cycles after its accept edge. Requests outside
// [MEM_START, MEM_START+MEM_SIZE) are still granted, but they never touch the array and they
// respond with err=1.
//
// Optional feature: define MEM_ARB_PERF_CNT_EN to add the grant_cnt and conflict_cnt
// performance counters.
//
// Ports:
//   clk_sys       system clock
//   rst_sys       synchronous active-high reset (memory contents are kept)
//   req/we        per-port request and write enable
//   be            per-port byte enables, port p at [4p+3:4p]
//   addr/wdata    per-port byte address and write data, port p at [32p+31:32p]
//   gnt           combinational grant, one-hot or zero
//   rvalid        one-cycle response pulse, one-hot or zero
//   rdata/err     per-port response data and error flag, qualified by rvalid
//   grant_cnt     (MEM_ARB_PERF_CNT_EN) saturating per-port count of accepted requests
//   conflict_cnt  (MEM_ARB_PERF_CNT_EN) saturating count of cycles with more than one req
//
// set_word(index, value) writes the array directly at zero time. It serves as the backdoor
// loader.

module mem_arb_ram #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned MEM_SIZE     = 65536,
  parameter logic [31:0] MEM_START    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          ARB_RR       = 1'b0
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   we,
  input  logic [NUM_PORTS*4-1:0] be,
  input  logic [NUM_PORTS*32-1:0] addr,
  input  logic [NUM_PORTS*32-1:0] wdata,
  output logic [NUM_PORTS-1:0]   gnt,
  output logic [NUM_PORTS-1:0]   rvalid,
  output logic [NUM_PORTS*32-1:0] rdata,
  output logic [NUM_PORTS-1:0]   err
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0] grant_cnt,
  output logic [31:0]            conflict_cnt
`endif
);

  localparam int unsigned AddrW    = $clog2(MEM_SIZE);
  localparam int unsigned Words    = MEM_SIZE / 4;
  localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] AddrMask = ~(32'(MEM_SIZE) - 32'd1);

  typedef struct packed {
    logic             valid;
    logic [PortW-1:0] port;
    logic             err;
    logic [31:0]      data;
  } rsp_t;

  logic [31:0]      mem [Words];

  logic [PortW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PortW-1:0] gnt_idx;
  logic             gnt_any;
  logic [31:0]      arb_j;

  logic             sel_we;
  logic [3:0]       sel_be;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             in_range;
  logic [AddrW-3:0] word_idx;
  logic [31:0]      rd_data;
  logic             unused_addr_lsb;

  rsp_t             pipe_q [READ_LATENCY];
  rsp_t             rsp_out;

  // Arbiter. The search starts at rr_ptr_q in round-robin mode and at port 0 otherwise.
  // Nothing is granted while reset is held.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    arb_j   = '0;
    if (!rst_sys) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        arb_j = i + (ARB_RR ? 32'(rr_ptr_q) : 32'd0);
        if (arb_j >= NUM_PORTS) arb_j = arb_j - NUM_PORTS;
        if (!gnt_any && req[arb_j[PortW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = arb_j[PortW-1:0];
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_RR && gnt_any) begin
      rr_ptr_d = (gnt_idx == PortW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  // Route the fields of the granted request to the memory port.
  always_comb begin
    sel_we    = we[gnt_idx];
    sel_be    = be[32'(gnt_idx)*4 +: 4];
    sel_addr  = addr[32'(gnt_idx)*32 +: 32];
    sel_wdata = wdata[32'(gnt_idx)*32 +: 32];
    in_range  = (sel_addr & AddrMask) == MEM_START;
    word_idx  = sel_addr[AddrW-1:2];
    // The array read happens before the same-edge write lands, so a read returns the old word.
    rd_data   = (in_range && !sel_we) ? mem[word_idx] : '0;
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  // The memory array has no reset, so its contents survive rst_sys.
  always_ff @(posedge clk_sys) begin
    if (gnt_any && in_range && sel_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

  // Response pipeline. It accepts at most one request per cycle, so responses never collide.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= '{valid: gnt_any,
                     port:  gnt_idx,
                     err:   gnt_any & ~in_range,
                     data:  gnt_any ? rd_data : 32'h0};
      for (int unsigned s = 1; s < READ_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rsp_out = pipe_q[READ_LATENCY-1];

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    err    = '0;
    if (rsp_out.valid) begin
      rvalid[rsp_out.port]                 = 1'b1;
      err[rsp_out.port]                    = rsp_out.err;
      rdata[32'(rsp_out.port)*32 +: 32]    = rsp_out.data;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] conflict_cnt_q;
  logic        multi_req;

  // This term is non-zero only when at least two req bits are set.
  assign multi_req = (req & (req - 1'b1)) != '0;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) grant_cnt_q[p] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (gnt_any && (grant_cnt_q[gnt_idx] != 32'hFFFF_FFFF)) begin
        grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 32'd1;
      end
      if (multi_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) grant_cnt[32*p +: 32] = grant_cnt_q[p];
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  function automatic void set_word(input int unsigned index, input logic [31:0] value);
    mem[index[AddrW-3:0]] = value;
  endfunction

endmodule

// File: tb/tb_mem_arb_ram.sv
// Directed testbench for mem_arb_ram. It uses three instances:
//   u_fp  2 ports, fixed priority, READ_LATENCY=1 (table-driven vectors)
//   u_rr  3 ports, round-robin,    READ_LATENCY=1
//   u_l3  2 ports, fixed priority, READ_LATENCY=3 (pipeline and mid-burst reset)

module tb_mem_arb_ram;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------------------------------------------------------- u_fp
  logic        fp_rst;
  logic [1:0]  fp_req, fp_we, fp_gnt, fp_rvalid, fp_err;
  logic [7:0]  fp_be;
  logic [63:0] fp_addr, fp_wdata, fp_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [63:0] fp_grant_cnt;
  logic [31:0] fp_conflict_cnt;
`endif

  mem_arb_ram #(
    .NUM_PORTS(2), .MEM_SIZE(65536), .MEM_START(32'h0), .READ_LATENCY(1), .ARB_RR(1'b0)
  ) u_fp (
    .clk_sys(clk), .rst_sys(fp_rst), .req(fp_req), .we(fp_we), .be(fp_be), .addr(fp_addr),
    .wdata(fp_wdata), .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .err(fp_err)
`ifdef MEM_ARB_PERF_CNT_EN
    , .grant_cnt(fp_grant_cnt), .conflict_cnt(fp_conflict_cnt)
`endif
  );

  // ---------------------------------------------------------------- u_rr
  logic        rr_rst;
  logic [2:0]  rr_req, rr_we, rr_gnt, rr_rvalid, rr_err;
  logic [11:0] rr_be;
  logic [95:0] rr_addr, rr_wdata, rr_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [95:0] rr_grant_cnt;
  logic [31:0] rr_conflict_cnt;
`endif

  mem_arb_ram #(
    .NUM_PORTS(3), .MEM_SIZE(65536), .MEM_START(32'h0), .READ_LATENCY(1), .ARB_RR(1'b1)
  ) u_rr (
    .clk_sys(clk), .rst_sys(rr_rst), .req(rr_req), .we(rr_we), .be(rr_be), .addr(rr_addr),
    .wdata(rr_wdata), .gnt(rr_gnt), .rvalid(rr_rvalid), .rdata(rr_rdata), .err(rr_err)
`ifdef MEM_ARB_PERF_CNT_EN
    , .grant_cnt(rr_grant_cnt), .conflict_cnt(rr_conflict_cnt)
`endif
  );

  // ---------------------------------------------------------------- u_l3
  logic        l3_rst;
  logic [1:0]  l3_req, l3_we, l3_gnt, l3_rvalid, l3_err;
  logic [7:0]  l3_be;
  logic [63:0] l3_addr, l3_wdata, l3_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [63:0] l3_grant_cnt;
  logic [31:0] l3_conflict_cnt;
`endif

  mem_arb_ram #(
    .NUM_PORTS(2), .MEM_SIZE(65536), .MEM_START(32'h0), .READ_LATENCY(3), .ARB_RR(1'b0)
  ) u_l3 (
    .clk_sys(clk), .rst_sys(l3_rst), .req(l3_req), .we(l3_we), .be(l3_be), .addr(l3_addr),
    .wdata(l3_wdata), .gnt(l3_gnt), .rvalid(l3_rvalid), .rdata(l3_rdata), .err(l3_err)
`ifdef MEM_ARB_PERF_CNT_EN
    , .grant_cnt(l3_grant_cnt), .conflict_cnt(l3_conflict_cnt)
`endif
  );

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each vector lists the inputs for one cycle and the outputs expected in that same cycle.
  // The rvalid, rdata and err fields therefore reflect the accept made in the cycle before.
  typedef struct packed {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic [1:0]  err;
  } vec_t;

  localparam int NumVecs = 17;
  vec_t vecs [NumVecs];

  initial begin
    logic [2:0]  exp3;
    logic [2:0]  exp_rv3;
    int          p;

    fp_rst = 1'b1; fp_req = '0; fp_we = '0; fp_be = '0; fp_addr = '0; fp_wdata = '0;
    rr_rst = 1'b1; rr_req = '0; rr_we = '0; rr_be = '1; rr_addr = '0; rr_wdata = '0;
    l3_rst = 1'b1; l3_req = '0; l3_we = '0; l3_be = '1; l3_addr = '0; l3_wdata = '0;

    u_fp.set_word(4, 32'hDEAD_BEEF);
    u_fp.set_word(0, 32'h1122_3344);
    u_fp.set_word(1, 32'h0102_0304);
    for (int i = 0; i < 3; i++) u_rr.set_word(8 + i, 32'hA000_0000 + i);
    for (int i = 0; i < 3; i++) u_l3.set_word(i, 32'hC000_0000 + i);

    //            rst   req    we     be     addr{p1,p0}                  wdata{p1,p0}
    //            gnt    rvalid rdata{p1,p0}                   err
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 8'hFF, {32'h10, 32'h10}, 64'h0,
                 2'b00, 2'b00, 64'h0, 2'b00};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 8'hFF, {32'h10, 32'h10}, 64'h0,
                 2'b01, 2'b00, 64'h0, 2'b00};
    vecs[2]  = '{1'b0, 2'b10, 2'b00, 8'hFF, {32'h10, 32'h10}, 64'h0,
                 2'b10, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 8'hFF, 64'h0, 64'h0,
                 2'b00, 2'b10, {32'hDEAD_BEEF, 32'h0}, 2'b00};
    vecs[4]  = '{1'b0, 2'b01, 2'b01, 8'hF5, 64'h0, {32'h0, 32'hAABB_CCDD},
                 2'b01, 2'b00, 64'h0, 2'b00};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 8'hFF, 64'h0, 64'h0,
                 2'b01, 2'b01, 64'h0, 2'b00};
    vecs[6]  = '{1'b0, 2'b10, 2'b00, 8'hFF, {32'h0001_0000, 32'h0}, 64'h0,
                 2'b10, 2'b01, {32'h0, 32'h11BB_33DD}, 2'b00};
    vecs[7]  = '{1'b0, 2'b10, 2'b10, 8'hFF, {32'h0001_0004, 32'h0}, {32'hFFFF_FFFF, 32'h0},
                 2'b10, 2'b10, 64'h0, 2'b10};
    vecs[8]  = '{1'b0, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h4}, 64'h0,
                 2'b01, 2'b10, 64'h0, 2'b10};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 8'hFF, 64'h0, 64'h0,
                 2'b00, 2'b01, {32'h0, 32'h0102_0304}, 2'b00};
    vecs[10] = '{1'b0, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h13}, 64'h0,
                 2'b01, 2'b00, 64'h0, 2'b00};
    vecs[11] = '{1'b0, 2'b00, 2'b00, 8'hFF, 64'h0, 64'h0,
                 2'b00, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00};
    vecs[12] = '{1'b0, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h10}, 64'h0,
                 2'b01, 2'b00, 64'h0, 2'b00};
    vecs[13] = '{1'b1, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h10}, 64'h0,
                 2'b00, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00};
    vecs[14] = '{1'b1, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h10}, 64'h0,
                 2'b00, 2'b00, 64'h0, 2'b00};
    vecs[15] = '{1'b0, 2'b01, 2'b00, 8'hFF, {32'h0, 32'h10}, 64'h0,
                 2'b01, 2'b00, 64'h0, 2'b00};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 8'hFF, 64'h0, 64'h0,
                 2'b00, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00};

    tick();
    tick();

    // Fixed priority, byte enables, out-of-range accesses, reset and retention.
    for (int i = 0; i < NumVecs; i++) begin
      fp_rst   = vecs[i].rst;
      fp_req   = vecs[i].req;
      fp_we    = vecs[i].we;
      fp_be    = vecs[i].be;
      fp_addr  = vecs[i].addr;
      fp_wdata = vecs[i].wdata;
      #2;
      check("fp_gnt",    i, 64'(fp_gnt),    64'(vecs[i].gnt));
      check("fp_rvalid", i, 64'(fp_rvalid), 64'(vecs[i].rvalid));
      check("fp_rdata",  i, fp_rdata,       vecs[i].rdata);
      check("fp_err",    i, 64'(fp_err),    64'(vecs[i].err));
      tick();
    end
    fp_req = '0;

    // Round-robin over 3 ports with all requests held. Port p reads word 8+p.
    rr_rst  = 1'b0;
    rr_addr = {32'h28, 32'h24, 32'h20};
    for (int k = 0; k < 7; k++) begin
      rr_req = (k < 6) ? 3'b111 : 3'b000;
      #2;
      exp3    = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
      exp_rv3 = (k == 0) ? 3'b000 : 3'(1 << ((k - 1) % 3));
      check("rr_gnt",    k, 64'(rr_gnt),    64'(exp3));
      check("rr_rvalid", k, 64'(rr_rvalid), 64'(exp_rv3));
      if (k > 0) begin
        p = (k - 1) % 3;
        check("rr_rdata", k, 64'(rr_rdata[32*p +: 32]), 64'(32'hA000_0000 + p));
      end
      tick();
    end
    // The pointer held through the idle cycle at 0. Partial request patterns follow.
    rr_req = 3'b110; #2; check("rr_ptr_gnt", 0, 64'(rr_gnt), 64'(3'b010)); tick();
    rr_req = 3'b101; #2; check("rr_ptr_gnt", 1, 64'(rr_gnt), 64'(3'b100)); tick();
    rr_req = 3'b011; #2; check("rr_ptr_gnt", 2, 64'(rr_gnt), 64'(3'b001)); tick();
    rr_req = 3'b000; #2; check("rr_ptr_rvalid", 3, 64'(rr_rvalid), 64'(3'b001)); tick();

    // READ_LATENCY=3: back-to-back reads of words 0..2 on port 0.
    l3_rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      l3_req  = (k < 3) ? 2'b01 : 2'b00;
      l3_addr = {32'h0, 32'(4 * k)};
      #2;
      check("l3_gnt", k, 64'(l3_gnt), (k < 3) ? 64'h1 : 64'h0);
      check("l3_rvalid", k, 64'(l3_rvalid), (k >= 3 && k <= 5) ? 64'h1 : 64'h0);
      if (k >= 3 && k <= 5) begin
        check("l3_rdata", k, 64'(l3_rdata[31:0]), 64'(32'hC000_0000 + (k - 3)));
      end
      tick();
    end
    // New burst with reset asserted in its second cycle. The first read is discarded.
    l3_req = 2'b01; l3_addr = '0;
    #2; check("l3_rst_gnt", 0, 64'(l3_gnt), 64'h1);
    tick();
    l3_rst = 1'b1;
    #2; check("l3_rst_gnt", 1, 64'(l3_gnt), 64'h0);
    tick();
    l3_rst = 1'b0; l3_req = '0;
    for (int k = 2; k < 8; k++) begin
      #2; check("l3_rst_rvalid", k, 64'(l3_rvalid), 64'h0);
      tick();
    end

`ifdef MEM_ARB_PERF_CNT_EN
    fp_rst = 1'b1; tick();
    fp_rst = 1'b0;
    fp_addr = {32'h10, 32'h10}; fp_we = '0;
    for (int k = 0; k < 4; k++) begin
      fp_req = 2'b11;
      tick();
    end
    fp_req = 2'b00;
    #2;
    check("perf_conflict", 0, 64'(fp_conflict_cnt), 64'd4);
    check("perf_grant_sum", 0, 64'(fp_grant_cnt[31:0]) + 64'(fp_grant_cnt[63:32]), 64'd4);
    fp_rst = 1'b1; tick();
    fp_rst = 1'b0;
    #2;
    check("perf_conflict_rst", 0, 64'(fp_conflict_cnt), 64'd0);
    check("perf_grant_rst", 0, fp_grant_cnt, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
